// File: rtl/lib_cpu_pkg.sv
// lib_cpu_pkg: shared CPU types for the EXECUTE/MEM-WB interface and system registers
package lib_cpu_pkg;

    localparam int XLEN      = 32;
    localparam int EX_MEM_AW = 6;

    // Architectural system registers fed back to decode (107 bits)
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            intr_en;
        logic [XLEN-1:0] intr_pc;
        logic [XLEN-1:0] intr_vec;
        logic            ack;
        logic            tx_req;
        logic [7:0]      tx_data;
    } sysreg_t;

    // One EXECUTE record per instruction (148 bits)
    typedef struct packed {
        logic                 w_rd;
        logic [XLEN-1:0]      x_rd;
        logic                 mem_r_req;
        logic                 mem_w_req;
        logic [EX_MEM_AW-1:0] mem_addr;
        sysreg_t              sr;
    } execute_t;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        LD_ISSUE,
        LD_WAIT
    } wb_state_e;

    localparam sysreg_t SYSREG_RESET = '0;

    // A store request wins over a simultaneous read request
    function automatic logic is_load(input execute_t ex);
        return ex.mem_r_req & ~ex.mem_w_req;
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory / write-back stage; performs data-memory access, commits
// the register-file write and holds the committed system registers.
//   clk, rst        clock, asynchronous active-high reset
//   ex_valid/ready  EXECUTE handshake (ex_in + rd_idx transfer on valid & ready)
//   dmem_*          single-port data RAM (read data one cycle after a read enable)
//   rf_*            register-file write port
//   sr_q            committed system registers (ack / tx_req are one-cycle pulses)
//   retire          one-cycle pulse per completed instruction
module mem_wb_stage
    import lib_cpu_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter int MEM_AW   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  execute_t          ex_in,
    input  logic [REG_AW-1:0] rd_idx,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [MEM_AW-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output sysreg_t           sr_q,
    output logic              retire
);

    wb_state_e         state, state_d;
    execute_t          hold;
    logic [REG_AW-1:0] hold_idx;
    logic              accept;
    logic              rf_en;

    always_comb begin
        accept  = ex_valid & ex_ready;
        rf_en   = hold.w_rd & ~hold.mem_w_req & ~(ZERO_REG && hold_idx == '0);
        state_d = state == IDLE     ? (accept ? (is_load(ex_in) ? LD_ISSUE : COMMIT) : IDLE) :
                  state == LD_ISSUE ? LD_WAIT :
                  state == LD_WAIT  ? COMMIT  : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_idx   <= '0;
            ex_ready   <= 1'b1;
            dmem_en    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            retire     <= 1'b0;
            sr_q       <= SYSREG_RESET;
        end else begin
            // Registered ready lags the state by one cycle, so it stays low
            // through the first IDLE cycle after a commit.
            ex_ready   <= (state == IDLE) & ~accept;
            dmem_en    <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            retire     <= 1'b0;
            sr_q.ack   <= 1'b0;
            sr_q.tx_req <= 1'b0;
            if (accept) begin
                hold     <= ex_in;
                hold_idx <= rd_idx;
            end
            if (state == LD_ISSUE) begin
                dmem_en   <= 1'b1;
                dmem_addr <= MEM_AW'(hold.mem_addr);
            end
            if (state == COMMIT) begin
                sr_q   <= hold.sr;
                retire <= 1'b1;
                if (hold.mem_w_req) begin
                    dmem_en    <= 1'b1;
                    dmem_we    <= 1'b1;
                    dmem_addr  <= MEM_AW'(hold.mem_addr);
                    dmem_wdata <= hold.x_rd;
                end else begin
                    // The read enable goes out at the end of LD_ISSUE, the RAM
                    // returns data during LD_WAIT's successor, so load data is
                    // sampled straight off dmem_rdata while in COMMIT.
                    rf_we    <= rf_en;
                    rf_waddr <= hold_idx;
                    rf_wdata <= is_load(hold) ? dmem_rdata : hold.x_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
    import lib_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    execute_t    ex_in = '0;
    logic [3:0]  rd_idx = '0;
    logic        dmem_en, dmem_we;
    logic [5:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    sysreg_t     sr_q;
    logic        retire;

    mem_wb_stage #(.REG_AW(4), .ZERO_REG(1'b1), .MEM_AW(6)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_in(ex_in), .rd_idx(rd_idx), .dmem_en(dmem_en), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sr_q(sr_q), .retire(retire)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [64];
    initial ram[5] = 32'h1234_5678;
    always @(posedge clk) begin
        if (dmem_en && dmem_we) ram[dmem_addr] <= dmem_wdata;
        if (dmem_en && !dmem_we) dmem_rdata <= ram[dmem_addr];
    end

    typedef struct packed {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        sysreg_t     sr;
    } rexp_t;

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } dexp_t;

    rexp_t rq[$];
    dexp_t dq[$];
    rexp_t mr;
    dexp_t md;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (retire) begin
                if (rq.size() > 0) begin
                    mr = rq.pop_front();
                    chk("sb_rf_we", rf_we, mr.we);
                    if (mr.we) begin
                        chk("sb_rf_waddr", rf_waddr, mr.waddr);
                        chk("sb_rf_wdata", rf_wdata, mr.wdata);
                    end
                    chk("sb_sr_q", sr_q, mr.sr);
                end else chk("sb_retire_extra", retire, 1'b0);
            end
            if (dmem_en) begin
                if (dq.size() > 0) begin
                    md = dq.pop_front();
                    chk("sb_dmem_we", dmem_we, md.we);
                    chk("sb_dmem_addr", dmem_addr, md.addr);
                    if (md.we) chk("sb_dmem_wdata", dmem_wdata, md.wdata);
                end else chk("sb_dmem_extra", dmem_en, 1'b0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one record from a negedge; returns at the negedge after the accept edge
    task automatic send(input logic w, input logic [31:0] x, input logic r, input logic wr,
                        input logic [5:0] a, input sysreg_t s, input logic [3:0] idx,
                        input logic [31:0] ld);
        int n;
        n = 0;
        while (!ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ex_ready, 1'b1);
        ex_in = '{w_rd: w, x_rd: x, mem_r_req: r, mem_w_req: wr, mem_addr: a, sr: s};
        rd_idx = idx;
        ex_valid = 1'b1;
        rq.push_back('{we: w & ~wr & (idx != 4'd0), waddr: idx,
                       wdata: (r & ~wr) ? ld : x, sr: s});
        if (wr || r) dq.push_back('{we: wr, addr: a, wdata: x});
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_in = '0;
        @(negedge clk);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ex_ready"}, ex_ready, 1'b1);
        chk({tag, "_dmem"}, {dmem_en, dmem_we, dmem_addr, dmem_wdata}, '0);
        chk({tag, "_rf"}, {rf_we, rf_waddr, rf_wdata}, '0);
        chk({tag, "_retire"}, retire, 1'b0);
        chk({tag, "_sr_q"}, sr_q, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sysreg_t z, s;
        z = '0;
        step();
        step();
        chk_idle_outs("reset");
        rst = 1'b0;
        step();

        // ALU result write
        send(1'b1, 32'h0000_00AB, 1'b0, 1'b0, 6'd0, z, 4'd3, 32'd0);
        chk("alu_ready_low", ex_ready, 1'b0);
        chk("alu_n0_retire", retire, 1'b0);
        step();
        chk("alu_rf", {rf_we, rf_waddr, rf_wdata, retire}, {1'b1, 4'd3, 32'hAB, 1'b1});
        chk("alu_n1_ready", ex_ready, 1'b0);
        step();
        chk("alu_n2_ready", ex_ready, 1'b1);
        chk("alu_n2_pulses", {rf_we, retire}, 2'b00);

        // Store
        send(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 6'h2A, z, 4'd4, 32'd0);
        step();
        chk("st_dmem", {dmem_en, dmem_we, dmem_addr, dmem_wdata},
            {1'b1, 1'b1, 6'h2A, 32'hDEAD_BEEF});
        chk("st_rf_we", {rf_we, retire}, 2'b01);
        step();
        chk("st_n2", {dmem_en, ex_ready}, 2'b01);

        // Load
        send(1'b1, 32'h0, 1'b1, 1'b0, 6'h05, z, 4'd7, 32'h1234_5678);
        step();
        chk("ld_issue", {dmem_en, dmem_we, dmem_addr, retire}, {1'b1, 1'b0, 6'h05, 1'b0});
        step();
        chk("ld_wait", {dmem_en, rf_we, retire}, 3'b000);
        step();
        chk("ld_commit", {rf_we, rf_waddr, rf_wdata, retire}, {1'b1, 4'd7, 32'h1234_5678, 1'b1});
        chk("ld_commit_ready", ex_ready, 1'b0);
        step();
        chk("ld_n4_ready", ex_ready, 1'b1);

        // System registers with pulsed ack / tx_req
        s = '0;
        s.pc = 32'h40;
        s.tx_req = 1'b1;
        s.tx_data = 8'h41;
        s.ack = 1'b1;
        send(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, s, 4'd1, 32'd0);
        step();
        chk("sr_n1", {sr_q.pc, sr_q.tx_req, sr_q.ack, sr_q.tx_data}, {32'h40, 1'b1, 1'b1, 8'h41});
        step();
        chk("sr_n2", {sr_q.pc, sr_q.tx_req, sr_q.ack, sr_q.tx_data}, {32'h40, 1'b0, 1'b0, 8'h41});

        // Write to register 0 is suppressed but still retires
        send(1'b1, 32'h55, 1'b0, 1'b0, 6'd0, z, 4'd0, 32'd0);
        step();
        chk("zero_reg", {rf_we, retire}, 2'b01);
        step();

        // Read and write both requested: a single store, no read
        send(1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 6'h10, z, 4'd2, 32'd0);
        step();
        chk("rw_store", {dmem_en, dmem_we, rf_we, retire}, 4'b1101);
        step();
        chk("rw_done", {dmem_en, ex_ready}, 2'b01);

        // Load back the earlier store
        send(1'b1, 32'h0, 1'b1, 1'b0, 6'h2A, z, 4'd9, 32'hDEAD_BEEF);
        step();
        step();
        step();
        chk("ld2_commit", {rf_we, rf_wdata}, {1'b1, 32'hDEAD_BEEF});
        step();

        // Reset during a load
        send(1'b1, 32'h0, 1'b1, 1'b0, 6'h05, z, 4'd6, 32'h1234_5678);
        step();
        chk("rst_ld_issue", dmem_en, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rq.delete();
        dq.delete();
        #1;
        chk_idle_outs("rst_async");
        step();
        step();
        chk("rst_no_commit", {rf_we, retire}, 2'b00);
        rst = 1'b0;
        step();
        chk("rst_release_ready", ex_ready, 1'b1);
        chk("rst_release_pulses", {rf_we, retire, dmem_en}, 3'b000);

        // Normal operation after reset
        send(1'b1, 32'h0000_0077, 1'b0, 1'b0, 6'd0, z, 4'd5, 32'd0);
        step();
        chk("post_rst_alu", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd5, 32'h77});
        step();
        step();

        chk("sb_drain_rq", rq.size(), 0);
        chk("sb_drain_dq", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
